// File: rtl/framebuffer_scanout.sv
// -----------------------------------------------------------------------------
// framebuffer_scanout
//
// Read-side engine for the output-controller pixel RAM. On a start pulse it
// walks one frame in raster order, issuing reads against a RAM with a
// synchronous read port (one cycle of read latency). The returned pixels are
// queued in a small FIFO and presented downstream as a valid/ready stream
// with start-of-frame and end-of-line markers. Reads are only issued when the
// FIFO is guaranteed to have room for them, so back-pressure never drops a
// pixel.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          asynchronous, active-high reset
//   start        one-cycle pulse: scan one frame (ignored while busy)
//   rd_en        RAM read strobe
//   rd_addr      RAM read address (row-major, base 0); holds while rd_en=0
//   rd_data      RAM read data, valid the cycle after rd_en
//   pix_data     output pixel (head of the FIFO)
//   pix_valid    pix_data / pix_sof / pix_eol are valid
//   pix_ready    downstream accepts when pix_valid && pix_ready
//   pix_sof      first pixel of the frame
//   pix_eol      last pixel of each line
//   busy         high from the cycle after an accepted start until frame_done
//   frame_done   one-cycle pulse on acceptance of the last pixel of the frame
//   underrun_cnt (only with SCANOUT_UNDERRUN_CNT_EN) saturating count of
//                cycles where downstream was ready but no pixel was available,
//                counted from the first pixel of the frame; cleared by start
//
// Build option: define SCANOUT_UNDERRUN_CNT_EN to add the underrun_cnt port.
// -----------------------------------------------------------------------------
module framebuffer_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
`ifdef SCANOUT_UNDERRUN_CNT_EN
  output logic              frame_done,
  output logic [15:0]       underrun_cnt
`else
  output logic              frame_done
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [X_W-1:0]   X_LAST  = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  // One FIFO entry: pixel plus the sideband tags computed at issue time.
  typedef struct packed {
    logic              sof;
    logic              eol;
    logic [DATA_W-1:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;

  // Read in flight: rd_en was high last cycle, so rd_data is valid now and
  // gets written into the FIFO this cycle together with its tags.
  logic              inflight_q;
  logic              tag_sof_q;
  logic              tag_eol_q;

  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  // ---------------------------------------------------------------------------
  // Issue / credit logic
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  credit_used;
  logic              issue;
  logic              last_issue;
  logic              start_accept;
  logic              push;
  logic              pop;
  entry_t            head;

  // The credit check deliberately ignores a pop happening this cycle: being
  // conservative keeps the path short and still sustains one pixel per clock.
  assign credit_used  = count_q + CNT_W'(inflight_q);
  assign issue        = (state_q == S_FETCH) && (credit_used < DEPTH_C);
  assign last_issue   = issue && (x_q == X_LAST) && (y_q == Y_LAST);
  assign start_accept = (state_q == S_IDLE) && start;

  assign push = inflight_q;
  assign pop  = pix_valid && pix_ready;

  assign rd_en   = issue;
  assign rd_addr = addr_q;

  // ---------------------------------------------------------------------------
  // Stream outputs, driven from the FIFO head. Gated with pix_valid so the
  // outputs read as zero while empty, regardless of stale storage contents.
  // ---------------------------------------------------------------------------
  assign head      = fifo_mem[rd_ptr_q];
  assign pix_valid = (count_q != '0);
  assign pix_data  = pix_valid ? head.data : '0;
  assign pix_sof   = pix_valid && head.sof;
  assign pix_eol   = pix_valid && head.eol;
  assign busy      = busy_q;

  // Once draining, nothing is in flight and only one entry remains, its
  // acceptance is the end of the frame.
  assign frame_done = (state_q == S_DRAIN) && !inflight_q &&
                      (count_q == CNT_W'(1)) && pop;

  // ---------------------------------------------------------------------------
  // Control FSM, raster counters and the issue-side pipeline stage
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      inflight_q <= 1'b0;
      tag_sof_q  <= 1'b0;
      tag_eol_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        tag_sof_q <= (x_q == '0) && (y_q == '0);
        tag_eol_q <= (x_q == X_LAST);
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
          end
        end

        S_FETCH: begin
          if (last_issue) begin
            // Address stays on the final pixel so rd_addr holds afterwards.
            state_q <= S_DRAIN;
          end else if (issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + Y_W'(1);
            end else begin
              x_q <= x_q + X_W'(1);
            end
          end
        end

        S_DRAIN: begin
          if (frame_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy. Simultaneous push and pop is legal at any
  // occupancy; the credit rule guarantees no push while full without a pop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers are reset,
  // and the outputs are gated by pix_valid, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{sof: tag_sof_q, eol: tag_eol_q, data: rd_data};
    end
  end

`ifdef SCANOUT_UNDERRUN_CNT_EN
  // ---------------------------------------------------------------------------
  // Underrun counter. The fill latency at the start of a frame is not an
  // underrun, so counting is armed only once the first pixel has appeared.
  // ---------------------------------------------------------------------------
  logic seen_first_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_first_q <= 1'b0;
      underrun_cnt <= '0;
    end else if (start_accept) begin
      seen_first_q <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (busy_q && pix_valid) seen_first_q <= 1'b1;
      if (busy_q && pix_ready && !pix_valid && seen_first_q &&
          (underrun_cnt != 16'hFFFF)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_framebuffer_scanout.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_scanout
//
// Self-checking bench for framebuffer_scanout with a 4x2 frame and a 4-entry
// FIFO. A RAM model returns mem[a] = 24'h000100 + a one cycle after rd_en.
// Expected pixels are queued when a frame is started and popped on every
// accepted pixel. A table of frame scenarios (ready patterns, extra start
// pulses) is run in a loop; mid-frame reset and the optional underrun counter
// are hand-written sequences. All monitoring runs in the single stimulus
// process, sampling on the falling edge.
// -----------------------------------------------------------------------------
module tb_framebuffer_scanout;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int AW    = 3;
  localparam int DW    = 24;
  localparam int DEPTH = 4;
  localparam int NPIX  = H * V;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_sof;
  logic          pix_eol;
  logic          busy;
  logic          frame_done;
`ifdef SCANOUT_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  framebuffer_scanout #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy),
`ifdef SCANOUT_UNDERRUN_CNT_EN
    .frame_done(frame_done), .underrun_cnt(underrun_cnt)
`else
    .frame_done(frame_done)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: synchronous read; garbage when not read so stray writes show.
  always @(posedge clk) begin
    rd_data <= rd_en ? (24'h000100 + 24'(rd_addr)) : 24'hBADBAD;
  end

`ifdef SCANOUT_UNDERRUN_CNT_EN
  // A 2-deep instance starves its own output, producing underrun gaps.
  logic          g_start;
  logic          g_rd_en;
  logic [AW-1:0] g_rd_addr;
  logic [DW-1:0] g_rd_data;
  logic [DW-1:0] g_pix_data;
  logic          g_pix_valid;
  logic          g_pix_ready;
  logic          g_pix_sof;
  logic          g_pix_eol;
  logic          g_busy;
  logic          g_frame_done;
  logic [15:0]   g_underrun;

  framebuffer_scanout #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(2)
  ) u_gap (
    .clk(clk), .rst(rst), .start(g_start),
    .rd_en(g_rd_en), .rd_addr(g_rd_addr), .rd_data(g_rd_data),
    .pix_data(g_pix_data), .pix_valid(g_pix_valid), .pix_ready(g_pix_ready),
    .pix_sof(g_pix_sof), .pix_eol(g_pix_eol), .busy(g_busy),
    .frame_done(g_frame_done), .underrun_cnt(g_underrun)
  );

  always @(posedge clk) begin
    g_rd_data <= g_rd_en ? (24'h000100 + 24'(g_rd_addr)) : 24'hBADBAD;
  end

  int g_gaps;
  int g_done;
  bit g_seen;
`endif

  // ---------------------------------------------------------------------------
  // Scoreboard and bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
  } pix_t;

  typedef struct {
    int mode;             // 0 ready high, 1 ready low 10 cycles, 2 toggling
    bit extra;            // extra start pulses at pixel 3 and on frame_done
    int exp_lat;          // start cycle to first pix_valid
    int exp_stall_reads;  // reads issued during the stall, -1 = not checked
    int exp_span;         // first to last acceptance, -1 = not checked
  } vec_t;

  pix_t          exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            exp_addr = 0;
  int            n_issued = 0;
  int            n_popped = 0;
  int            last_rd = 0;
  int            fd_cnt = 0;
  int            pops_frame = 0;
  int            first_valid_cyc = -1;
  int            first_acc_cyc = -1;
  int            last_acc_cyc = -1;
  bit            prev_hold = 1'b0;
  bit            prev_fd = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    int   entries;
    pix_t e;
    if (rst) begin
      exp_q.delete();
      n_issued  = 0;
      n_popped  = 0;
      last_rd   = 0;
      prev_hold = 1'b0;
      prev_fd   = 1'b0;
      return;
    end
    // Entries held in the FIFO: reads whose data has already been written.
    entries = n_issued - last_rd - n_popped;
    check("fifo_no_overflow", 32'(entries <= DEPTH), 32'(1));
    check("pix_valid_vs_occupancy", 32'(pix_valid), 32'(entries != 0));
    if (prev_hold) check("pix_data_stable", 32'(pix_data), 32'(prev_data));
    if (rd_en) begin
      check("rd_addr", 32'(rd_addr), 32'(exp_addr));
      exp_addr++;
      n_issued++;
    end
    last_rd = rd_en ? 1 : 0;
    if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (pix_valid && pix_ready) begin
      check("scoreboard_has_entry", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pix_data", 32'(pix_data), 32'(e.data));
        check("pix_sof", 32'(pix_sof), 32'(e.sof));
        check("pix_eol", 32'(pix_eol), 32'(e.eol));
      end
      n_popped++;
      pops_frame++;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
    end
    if (prev_fd) check("busy_low_after_done", 32'(busy), 32'(0));
    if (frame_done) begin
      fd_cnt++;
      check("done_on_accept", 32'(pix_valid && pix_ready), 32'(1));
      check("done_scoreboard_empty", 32'(exp_q.size()), 32'(0));
      check("busy_during_done", 32'(busy), 32'(1));
    end
    prev_fd   = frame_done;
    prev_hold = pix_valid && !pix_ready;
    prev_data = pix_data;
  endtask

  task automatic tick(input bit start_on_done);
    @(negedge clk);
    monitor();
`ifdef SCANOUT_UNDERRUN_CNT_EN
    if (!rst) begin
      if (g_pix_valid) g_seen = 1'b1;
      if (g_busy && g_pix_ready && !g_pix_valid && g_seen) g_gaps++;
      if (g_frame_done) g_done++;
    end
`endif
    if (start_on_done && frame_done) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef SCANOUT_UNDERRUN_CNT_EN
    g_start = 1'b0;
`endif
    cyc++;
  endtask

  task automatic load_frame();
    pix_t e;
    for (int i = 0; i < NPIX; i++) begin
      e.data = 24'h000100 + 24'(i);
      e.sof  = (i == 0);
      e.eol  = ((i % H) == H - 1);
      exp_q.push_back(e);
    end
    exp_addr        = 0;
    fd_cnt          = 0;
    pops_frame      = 0;
    first_valid_cyc = -1;
    first_acc_cyc   = -1;
    last_acc_cyc    = -1;
  endtask

  task automatic run_frame(input int mode, input bit extra,
                           output int lat, output int stall_reads,
                           output int span, output bit timeout);
    int start_cyc;
    bit pulsed;
    bit done;
    load_frame();
    stall_reads = -1;
    pulsed      = 1'b0;
    done        = 1'b0;
    start_cyc   = cyc;
    start       = 1'b1;
    for (int k = 0; k < 300; k++) begin
      case (mode)
        1:       pix_ready = (k >= 10);
        2:       pix_ready = ((k % 2) == 0);
        default: pix_ready = 1'b1;
      endcase
      if (k == 10) stall_reads = exp_addr;
      if (extra && !pulsed && pops_frame == 3) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      tick(extra);
      if (fd_cnt != 0) begin
        done = 1'b1;
        break;
      end
    end
    pix_ready = 1'b1;
    repeat (4) tick(1'b0);
    timeout = !done;
    lat     = first_valid_cyc - start_cyc;
    span    = last_acc_cyc - first_acc_cyc;
  endtask

  vec_t vecs[4];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int lat;
    int stall_reads;
    int span;
    bit timeout;

    vecs[0] = '{mode: 0, extra: 1'b0, exp_lat: 3, exp_stall_reads: -1, exp_span: 7};
    vecs[1] = '{mode: 1, extra: 1'b0, exp_lat: 3, exp_stall_reads: 4,  exp_span: -1};
    vecs[2] = '{mode: 2, extra: 1'b0, exp_lat: 3, exp_stall_reads: -1, exp_span: -1};
    vecs[3] = '{mode: 0, extra: 1'b1, exp_lat: 3, exp_stall_reads: -1, exp_span: 7};

    rst       = 1'b1;
    start     = 1'b0;
    pix_ready = 1'b1;
`ifdef SCANOUT_UNDERRUN_CNT_EN
    g_start     = 1'b0;
    g_pix_ready = 1'b1;
    g_gaps      = 0;
    g_done      = 0;
    g_seen      = 1'b0;
`endif

    // Reset state.
    repeat (3) tick(1'b0);
    check("rst_rd_en", 32'(rd_en), 32'(0));
    check("rst_rd_addr", 32'(rd_addr), 32'(0));
    check("rst_pix_valid", 32'(pix_valid), 32'(0));
    check("rst_pix_data", 32'(pix_data), 32'(0));
    check("rst_pix_sof", 32'(pix_sof), 32'(0));
    check("rst_pix_eol", 32'(pix_eol), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    rst = 1'b0;
    repeat (2) tick(1'b0);

    // Table-driven frames.
    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].mode, vecs[v].extra, lat, stall_reads, span, timeout);
      check($sformatf("v%0d_timeout", v), 32'(timeout), 32'(0));
      check($sformatf("v%0d_pixels", v), 32'(pops_frame), 32'(NPIX));
      check($sformatf("v%0d_frame_done_count", v), 32'(fd_cnt), 32'(1));
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      if (vecs[v].exp_stall_reads >= 0)
        check($sformatf("v%0d_stall_reads", v), 32'(stall_reads),
              32'(vecs[v].exp_stall_reads));
      if (vecs[v].exp_span >= 0)
        check($sformatf("v%0d_span", v), 32'(span), 32'(vecs[v].exp_span));
      check($sformatf("v%0d_busy_idle", v), 32'(busy), 32'(0));
    end
`ifdef SCANOUT_UNDERRUN_CNT_EN
    check("main_underrun_zero", 32'(underrun_cnt), 32'(0));
`endif

    // Asynchronous reset after two accepted pixels aborts the frame.
    load_frame();
    pix_ready = 1'b1;
    start     = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0);
      if (pops_frame >= 2) break;
    end
    check("abort_reached_pixel2", 32'(pops_frame), 32'(2));
    check("abort_valid_before", 32'(pix_valid), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("abort_pix_valid", 32'(pix_valid), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_rd_en", 32'(rd_en), 32'(0));
    check("abort_frame_done", 32'(frame_done), 32'(0));
    repeat (2) tick(1'b0);
    #2;
    rst = 1'b0;
    fd_cnt = 0;
    repeat (4) tick(1'b0);
    check("abort_no_frame_done", 32'(fd_cnt), 32'(0));
    check("abort_idle_busy", 32'(busy), 32'(0));
    check("abort_idle_rd_en", 32'(rd_en), 32'(0));
    run_frame(0, 1'b0, lat, stall_reads, span, timeout);
    check("restart_timeout", 32'(timeout), 32'(0));
    check("restart_pixels", 32'(pops_frame), 32'(NPIX));
    check("restart_frame_done_count", 32'(fd_cnt), 32'(1));
    check("restart_latency", 32'(lat), 32'(3));

`ifdef SCANOUT_UNDERRUN_CNT_EN
    // Underrun counter on the starved 2-deep instance.
    g_gaps  = 0;
    g_done  = 0;
    g_seen  = 1'b0;
    g_start = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick(1'b0);
      if (g_done != 0) break;
    end
    repeat (2) tick(1'b0);
    check("gap_frame_done", 32'(g_done), 32'(1));
    check("gap_cycles_present", 32'(g_gaps != 0), 32'(1));
    check("underrun_cnt", 32'(g_underrun), 32'(g_gaps));
    g_done  = 0;
    g_start = 1'b1;
    tick(1'b0);
    check("underrun_cleared_by_start", 32'(g_underrun), 32'(0));
    for (int k = 0; k < 200; k++) begin
      tick(1'b0);
      if (g_done != 0) break;
    end
    check("gap_second_frame_done", 32'(g_done), 32'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
- Read-side engine for the output-controller pixel RAM.
- Walks the frame buffer in raster order, issuing reads against the RAM's synchronous read port (1-cycle latency).
- Presents pixels as a valid/ready stream with start-of-frame and end-of-line markers to the display/serializer stage.
- Buffers in-flight read data in a small FIFO so downstream back-pressure never drops a pixel.

Parameters:
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- ADDR_W, 19, RAM read-address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- DATA_W, 24, pixel width (RGB888)
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin scanning one frame
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  DATA_W  RAM read data, valid the cycle after rd_en
- pix_data  out  DATA_W  output pixel
- pix_valid  out  1  pix_data/pix_sof/pix_eol valid
- pix_ready  in  1  downstream accepts when pix_valid && pix_ready
- pix_sof  out  1  high with the first pixel of the frame (address 0)
- pix_eol  out  1  high with the last pixel of each line
- busy  out  1  high from the cycle after accepted start until frame_done
- frame_done  out  1  one-cycle pulse when the last pixel is accepted downstream

Behaviour:
- Reset is one clock; rst is asynchronous, active-high. While asserted, all outputs are 0, FSM=IDLE, counters=0, FIFO empty, no read in flight. Asserting rst mid-frame aborts the frame with no frame_done. After deassertion, wait for a new start.
- FSM states:
  - IDLE: start=1 -> FETCH, clear x/y counters and address.
  - FETCH: issue reads.
    - rd_en=1 when occupancy + inflight < FIFO_DEPTH. Occupancy = FIFO count; inflight = 1 if rd_en was high last cycle.
    - rd_addr = y*H_ACTIVE + x, row-major, base 0. Maintain it as an incrementing counter; no multiplier.
    - On each issued read: x increments. At x=H_ACTIVE-1, x wraps to 0 and y increments.
    - After issuing address H_ACTIVE*V_ACTIVE-1 -> DRAIN.
  - DRAIN: rd_en=0. When FIFO empty, no read in flight, and final pixel accepted -> pulse frame_done, -> IDLE.
- Sideband tags: sof (x=0,y=0) and eol (x=H_ACTIVE-1) are computed at issue time. They are delayed one cycle alongside the read and written into the FIFO with rd_data (DATA_W+2 bits per entry).
- FIFO:
  - Write on the cycle after rd_en.
  - Read on pix_valid && pix_ready.
  - pix_valid = !empty; outputs are driven from the head entry.
  - Simultaneous write and read is allowed at any occupancy, including full.
  - The credit rule guarantees no write to a full FIFO. Overflow is a design error; the bench asserts it never occurs.
- rd_addr holds its last value when rd_en=0. rd_data is ignored except the cycle after rd_en.
- start while busy is ignored. start in the same cycle as frame_done is ignored; the next frame needs a fresh pulse.
- Pixel throughput: 1 per clock when pix_ready is held high. Latency from start to first pix_valid is 3 cycles (FSM, RAM read, FIFO write).
- pix_data is held stable while pix_valid && !pix_ready.

Optional Feature:
- Macro: SCANOUT_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt [15:0].
  - Increments each cycle with busy && pix_ready && !pix_valid, excluding the cycles before the first pixel of the frame.
  - Saturates at 16'hFFFF.
  - Clears on rst and on each accepted start.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan (H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4, RAM model preloaded mem[a]=24'h000100+a):
1. rst held, then start, pix_ready=1 -> rd_addr 0..7, pixels 24'h000100..24'h000107 on consecutive cycles; first pix_valid 3 cycles after start; sof on 0x100 only; eol on 0x103 and 0x107; frame_done on the acceptance cycle of 0x107; busy falls next cycle.
2. pix_ready=0 for 10 cycles after start -> exactly 4 reads issued; rd_en low; pix_data stable at 0x100. Releasing ready delivers all 8 pixels in order with no loss or duplication.
3. pix_ready toggling 1/0 every cycle -> 8 pixels in order; the FIFO never exceeds 4 entries; no overflow.
4. start pulsed again at pixel 3 and again on the frame_done cycle -> both ignored; exactly one frame_done, busy low afterward.
5. rst asserted asynchronously mid-frame (after pixel 2) -> pix_valid, busy, and rd_en low immediately; no frame_done. A new start then produces a full frame beginning at 0x100 with sof.
6. With SCANOUT_UNDERRUN_CNT_EN: a RAM model with rd_en honoured every other cycle via ready toggling upstream produces gaps -> underrun_cnt equals the counted gap cycles. Cleared to 0 by the next start.
